// File: rtl/dac_seq_pkg.sv
// Shared types and constants for the AD5754 update sequencer.
// DAC_OFFSET_BINARY_EN selects a mid-scale (16'h8000) reset/hold value.
package dac_seq_pkg;
  typedef enum logic [2:0] {
    S_INIT_CLR, S_INIT_STEP, S_INIT_GAP, S_IDLE, S_CLR, S_STEP, S_GAP
  } state_t;

  localparam int TRIG_ADV = 0;
  localparam int TRIG_CLR = 1;
  localparam int TRIG_ACT = 2;

  localparam int FRAME_GAP_D   = 56;
  localparam int INIT_FRAMES_D = 9;
  localparam int NUM_CH_D      = 4;

  localparam int DATA_W    = 16;
  localparam int N_DATA_CH = 4;

  typedef logic [N_DATA_CH-1:0][DATA_W-1:0] ch_vec_t;

`ifdef DAC_OFFSET_BINARY_EN
  localparam logic [DATA_W-1:0] CH_RST_VAL = 16'h8000;
`else
  localparam logic [DATA_W-1:0] CH_RST_VAL = 16'h0000;
`endif
endpackage

// File: rtl/dac_update_sequencer_if.sv
// Setpoint valid/ready bus: producer is master, sequencer is slave.
interface dac_update_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_ch_a;
  logic [15:0] in_ch_b;
  logic [15:0] in_ch_c;
  logic [15:0] in_ch_d;

  modport master (output in_valid, in_ch_a, in_ch_b, in_ch_c, in_ch_d, input in_ready);
  modport slave  (input in_valid, in_ch_a, in_ch_b, in_ch_c, in_ch_d, output in_ready);
endinterface

// File: rtl/dac_seq_shadow.sv
// Shadow setpoint register with pending flag and registered in_ready.
// DAC_OFFSET_BINARY_EN: two's-complement inputs are stored as offset binary.
module dac_seq_shadow
  import dac_seq_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   xfer,
  dac_update_sequencer_if.slave  sp,
  output ch_vec_t                shadow,
  output logic                   pending
);
  logic    accept, pending_n;
  ch_vec_t load_val;

  assign accept    = sp.in_valid & sp.in_ready;
  // A same-cycle accept wins: the transfer already used the old shadow.
  assign pending_n = accept | (pending & ~xfer);

  always_comb begin
    load_val = {sp.in_ch_d, sp.in_ch_c, sp.in_ch_b, sp.in_ch_a};
`ifdef DAC_OFFSET_BINARY_EN
    for (int i = 0; i < N_DATA_CH; i++)
      load_val[i][DATA_W-1] = ~load_val[i][DATA_W-1];
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow      <= {N_DATA_CH{CH_RST_VAL}};
      pending     <= 1'b0;
      sp.in_ready <= 1'b0;
    end else begin
      if (accept) shadow <= load_val;
      pending     <= pending_n;
      sp.in_ready <= ~pending_n;
    end
  end
endmodule

// File: rtl/dac_update_sequencer.sv
// AD5754 driver control stage: one init pass after reset, then a
// clear + NUM_CH frame-advance pass per update strobe, FRAME_GAP clks apart.
module dac_update_sequencer
  import dac_seq_pkg::*;
#(
  parameter int FRAME_GAP   = FRAME_GAP_D,
  parameter int INIT_FRAMES = INIT_FRAMES_D,
  parameter int NUM_CH      = NUM_CH_D
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  update_stb,
  dac_update_sequencer_if.slave sp,
  output logic [2:0]            dac_trig,
  output logic [DATA_W-1:0]     dac_ch_a,
  output logic [DATA_W-1:0]     dac_ch_b,
  output logic [DATA_W-1:0]     dac_ch_c,
  output logic [DATA_W-1:0]     dac_ch_d,
  output logic                  busy,
  output logic                  init_done,
  output logic [7:0]            overrun_cnt
);
  localparam int GAP_W     = $clog2(FRAME_GAP);
  localparam int MAX_STEPS = (INIT_FRAMES > NUM_CH) ? INIT_FRAMES : NUM_CH;
  localparam int STEP_W    = $clog2(MAX_STEPS + 1);

  state_t             state, state_n;
  logic [GAP_W-1:0]   gap_cnt, gap_n;
  logic [STEP_W-1:0]  steps, steps_n;
  logic [2:0]         trig_n;
  logic               done_n, xfer, pending;
  ch_vec_t            shadow, dac_ch_q;

  dac_seq_shadow u_shadow (
    .clk     (clk),
    .reset_n (reset_n),
    .xfer    (xfer),
    .sp      (sp),
    .shadow  (shadow),
    .pending (pending)
  );

  always_comb begin
    state_n = state;
    gap_n   = gap_cnt;
    steps_n = steps;
    done_n  = init_done;
    xfer    = 1'b0;
    case (state)
      // Reset parks here with trig cleared; hold one cycle so the clear is emitted.
      S_INIT_CLR: if (dac_trig[TRIG_CLR]) begin
        state_n = S_INIT_STEP;
        steps_n = STEP_W'(INIT_FRAMES);
      end
      S_CLR: begin
        state_n = S_STEP;
        steps_n = STEP_W'(NUM_CH);
      end
      S_INIT_STEP, S_STEP: begin
        gap_n   = GAP_W'(FRAME_GAP - 2);
        steps_n = steps - 1'b1;
        state_n = (state == S_INIT_STEP) ? S_INIT_GAP : S_GAP;
      end
      S_INIT_GAP, S_GAP: begin
        if (gap_cnt != '0)
          gap_n = gap_cnt - 1'b1;
        else if (steps != '0)
          state_n = (state == S_INIT_GAP) ? S_INIT_STEP : S_STEP;
        else begin
          state_n = S_IDLE;
          if (state == S_INIT_GAP) done_n = 1'b1;
        end
      end
      S_IDLE: if (update_stb) begin
        state_n = S_CLR;
        xfer    = 1'b1;
      end
      default: state_n = S_INIT_CLR;
    endcase

    // Outputs are registered decodes of the next state.
    trig_n           = '0;
    trig_n[TRIG_ADV] = (state_n == S_INIT_STEP) || (state_n == S_STEP);
    trig_n[TRIG_CLR] = (state_n == S_CLR) ||
                       ((state_n == S_INIT_CLR) && !dac_trig[TRIG_CLR]);
    trig_n[TRIG_ACT] = (state_n != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_INIT_CLR;
      gap_cnt     <= '0;
      steps       <= '0;
      dac_trig    <= '0;
      busy        <= 1'b1;
      init_done   <= 1'b0;
      overrun_cnt <= '0;
      dac_ch_q    <= {N_DATA_CH{CH_RST_VAL}};
    end else begin
      state     <= state_n;
      gap_cnt   <= gap_n;
      steps     <= steps_n;
      dac_trig  <= trig_n;
      busy      <= (state_n != S_IDLE);
      init_done <= done_n;
      if (xfer && pending) dac_ch_q <= shadow;
      if (update_stb && (state != S_IDLE) && (overrun_cnt != 8'hFF))
        overrun_cnt <= overrun_cnt + 8'd1;
    end
  end

  assign dac_ch_a = dac_ch_q[0];
  assign dac_ch_b = dac_ch_q[1];
  assign dac_ch_c = dac_ch_q[2];
  assign dac_ch_d = dac_ch_q[3];
endmodule

// File: tb/tb_dac_update_sequencer.sv
// Directed bench for dac_update_sequencer with FRAME_GAP=56, INIT_FRAMES=9, NUM_CH=4.
module tb_dac_update_sequencer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        update_stb = 1'b0;
  logic [2:0]  dac_trig;
  logic [15:0] dac_ch_a, dac_ch_b, dac_ch_c, dac_ch_d;
  logic        busy, init_done;
  logic [7:0]  overrun_cnt;
  int          errors = 0;
  int          checks = 0;

`ifdef DAC_OFFSET_BINARY_EN
  localparam logic [15:0] RST_V  = 16'h8000;
  localparam logic [63:0] ENC_EX = {16'hFFFF, 16'h8000, 16'h0000, 16'h7FFF};
`else
  localparam logic [15:0] RST_V  = 16'h0000;
  localparam logic [63:0] ENC_EX = {16'h7FFF, 16'h0000, 16'h8000, 16'hFFFF};
`endif

  dac_update_sequencer_if sp();

  dac_update_sequencer #(.FRAME_GAP(56), .INIT_FRAMES(9), .NUM_CH(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .update_stb  (update_stb),
    .sp          (sp),
    .dac_trig    (dac_trig),
    .dac_ch_a    (dac_ch_a),
    .dac_ch_b    (dac_ch_b),
    .dac_ch_c    (dac_ch_c),
    .dac_ch_d    (dac_ch_d),
    .busy        (busy),
    .init_done   (init_done),
    .overrun_cnt (overrun_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] enc(input logic [15:0] v);
`ifdef DAC_OFFSET_BINARY_EN
    return {~v[15], v[14:0]};
`else
    return v;
`endif
  endfunction

  function automatic logic [63:0] dac_all();
    return {dac_ch_d, dac_ch_c, dac_ch_b, dac_ch_a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_set(input logic [63:0] v);
    sp.in_ch_d = v[63:48];
    sp.in_ch_c = v[47:32];
    sp.in_ch_b = v[31:16];
    sp.in_ch_a = v[15:0];
  endtask

  task automatic run_pass(input logic [63:0] exp_ch, input string name);
    int adv = 0;
    int ch_bad = 0;
    int n = 0;
    update_stb = 1'b1;
    tick();
    update_stb = 1'b0;
    while (busy === 1'b1 && n < 300) begin
      if (dac_trig[0] === 1'b1) adv++;
      if (dac_all() !== exp_ch) ch_bad++;
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0 || adv != 4 || ch_bad != 0) begin
      errors++;
      $display("FAIL %s_pass busy=%b adv=%0d ch_bad=%0d ch=%h required busy=0 adv=4 ch_bad=0 ch=%h",
               name, busy, adv, ch_bad, dac_all(), exp_ch);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    sp.in_valid = 1'b0;
    load_set(64'h0);
    repeat (3) tick();
    checks++;
    if (dac_trig !== 3'b000) begin errors++; $display("FAIL reset_trig got=%b required=000", dac_trig); end
    checks++;
    if (dac_all() !== {4{RST_V}}) begin errors++; $display("FAIL reset_ch got=%h required=%h", dac_all(), {4{RST_V}}); end
    checks++;
    if (busy !== 1'b1 || init_done !== 1'b0) begin
      errors++; $display("FAIL reset_flags busy=%b init_done=%b required 1/0", busy, init_done);
    end
    checks++;
    if (overrun_cnt !== 8'h00) begin errors++; $display("FAIL reset_overrun got=%0d required=0", overrun_cnt); end
    checks++;
    if (sp.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b required=0", sp.in_ready); end
  endtask

  task automatic test_init();
    int bad_trig = 0;
    int bad_ch = 0;
    int first_bad = -1;
    logic [2:0] exp;
    reset_n = 1'b1;
    for (int c = 1; c <= 515; c++) begin
      tick();
      exp = {c < 506, c == 1, (c >= 2 && c <= 450 && (c - 2) % 56 == 0)};
      if (dac_trig !== exp || busy !== exp[2]) begin
        bad_trig++;
        if (first_bad < 0) first_bad = c;
      end
      if (dac_all() !== {4{RST_V}}) bad_ch++;
      update_stb = (c == 100);
    end
    checks++;
    if (bad_trig != 0) begin errors++; $display("FAIL init_trig_seq bad_cycles=%0d first=%0d required=0", bad_trig, first_bad); end
    checks++;
    if (bad_ch != 0) begin errors++; $display("FAIL init_ch_hold bad_cycles=%0d required=0", bad_ch); end
    checks++;
    if (init_done !== 1'b1) begin errors++; $display("FAIL init_done got=%b required=1", init_done); end
    checks++;
    if (overrun_cnt !== 8'd1) begin errors++; $display("FAIL init_overrun got=%0d required=1", overrun_cnt); end
    checks++;
    if (sp.in_ready !== 1'b1) begin errors++; $display("FAIL init_in_ready got=%b required=1", sp.in_ready); end
  endtask

  task automatic test_update();
    int bad_trig = 0;
    int bad_ch = 0;
    int first_bad = -1;
    logic [2:0]  exp;
    logic [63:0] exp_ch;
    exp_ch = {enc(16'h4444), enc(16'h3333), enc(16'h2222), enc(16'h1111)};
    load_set({16'h4444, 16'h3333, 16'h2222, 16'h1111});
    sp.in_valid = 1'b1;
    tick();
    sp.in_valid = 1'b0;
    checks++;
    if (sp.in_ready !== 1'b0) begin errors++; $display("FAIL upd_pending_ready got=%b required=0", sp.in_ready); end
    update_stb = 1'b1;
    tick();
    update_stb = 1'b0;
    checks++;
    if (dac_trig !== 3'b110 || dac_all() !== exp_ch || sp.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL upd_first_cycle trig=%b ch=%h rdy=%b required trig=110 ch=%h rdy=1",
               dac_trig, dac_all(), sp.in_ready, exp_ch);
    end
    for (int s = 2; s <= 232; s++) begin
      tick();
      exp = {s < 226, 1'b0, (s == 2 || s == 58 || s == 114 || s == 170)};
      if (dac_trig !== exp || busy !== exp[2]) begin
        bad_trig++;
        if (first_bad < 0) first_bad = s;
      end
      if (dac_all() !== exp_ch) bad_ch++;
      update_stb = (s == 80);
    end
    checks++;
    if (bad_trig != 0) begin errors++; $display("FAIL upd_trig_seq bad_cycles=%0d first=%0d required=0", bad_trig, first_bad); end
    checks++;
    if (bad_ch != 0) begin errors++; $display("FAIL upd_ch_stable bad_cycles=%0d required=0", bad_ch); end
    checks++;
    if (overrun_cnt !== 8'd2) begin errors++; $display("FAIL upd_overrun got=%0d required=2", overrun_cnt); end
  endtask

  task automatic test_pending_hold();
    logic [63:0] x_set, y_set;
    int n = 0;
    int ch_bad = 0;
    x_set = {16'hA4A4, 16'hA3A3, 16'hA2A2, 16'hA1A1};
    y_set = {16'h5B4B, 16'h5B3B, 16'h5B2B, 16'h5B1B};
    load_set(x_set);
    sp.in_valid = 1'b1;
    tick();
    load_set(y_set);
    tick();
    checks++;
    if (sp.in_ready !== 1'b0) begin errors++; $display("FAIL hold_ready got=%b required=0", sp.in_ready); end
    update_stb = 1'b1;
    tick();
    update_stb = 1'b0;
    checks++;
    if (dac_all() !== {enc(x_set[63:48]), enc(x_set[47:32]), enc(x_set[31:16]), enc(x_set[15:0])} ||
        sp.in_ready !== 1'b1) begin
      errors++; $display("FAIL hold_first_set ch=%h rdy=%b required first set, rdy=1", dac_all(), sp.in_ready);
    end
    tick();
    sp.in_valid = 1'b0;
    checks++;
    if (sp.in_ready !== 1'b0) begin errors++; $display("FAIL hold_second_accept rdy=%b required=0", sp.in_ready); end
    while (busy === 1'b1 && n < 300) begin
      if (dac_all() !== {enc(x_set[63:48]), enc(x_set[47:32]), enc(x_set[31:16]), enc(x_set[15:0])}) ch_bad++;
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0 || ch_bad != 0) begin
      errors++; $display("FAIL hold_pass busy=%b ch_bad=%0d required busy=0 ch_bad=0", busy, ch_bad);
    end
    run_pass({enc(y_set[63:48]), enc(y_set[47:32]), enc(y_set[31:16]), enc(y_set[15:0])}, "held");
  endtask

  task automatic test_refresh();
    logic [63:0] y_exp;
    y_exp = {enc(16'h5B4B), enc(16'h5B3B), enc(16'h5B2B), enc(16'h5B1B)};
    run_pass(y_exp, "refresh");
    checks++;
    if (sp.in_ready !== 1'b1) begin errors++; $display("FAIL refresh_ready got=%b required=1", sp.in_ready); end
  endtask

  task automatic test_encode();
    load_set({16'h7FFF, 16'h0000, 16'h8000, 16'hFFFF});
    sp.in_valid = 1'b1;
    tick();
    sp.in_valid = 1'b0;
    run_pass(ENC_EX, "encode");
  endtask

  task automatic test_mid_reset();
    int n = 0;
    update_stb = 1'b1;
    tick();
    update_stb = 1'b0;
    repeat (30) tick();
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (dac_trig !== 3'b000 || dac_all() !== {4{RST_V}}) begin
      errors++; $display("FAIL midrst_async trig=%b ch=%h required trig=000 ch=%h", dac_trig, dac_all(), {4{RST_V}});
    end
    checks++;
    if (busy !== 1'b1 || init_done !== 1'b0 || overrun_cnt !== 8'h00) begin
      errors++; $display("FAIL midrst_flags busy=%b done=%b ovr=%0d required 1/0/0", busy, init_done, overrun_cnt);
    end
    tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (dac_trig !== 3'b110) begin errors++; $display("FAIL midrst_clr got=%b required=110", dac_trig); end
    tick();
    checks++;
    if (dac_trig !== 3'b101) begin errors++; $display("FAIL midrst_adv got=%b required=101", dac_trig); end
    while (init_done !== 1'b1 && n < 600) begin
      tick();
      n++;
    end
    checks++;
    if (init_done !== 1'b1 || busy !== 1'b0 || dac_all() !== {4{RST_V}}) begin
      errors++; $display("FAIL midrst_reinit done=%b busy=%b ch=%h required 1/0/%h",
                         init_done, busy, dac_all(), {4{RST_V}});
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_update();
    test_pending_hold();
    test_refresh();
    test_encode();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dac_update_sequencer.md
Name: dac_update_sequencer

Overview:
Upstream control stage for the AD5754 serial DAC driver. It accepts four channel setpoints through a valid/ready handshake and runs a one-time power-up/range init pass after reset. On each periodic update strobe it presents stable channel data and drives the driver's 3-bit trig bus: bit 1 clears the driver's frame-address counter, and bit 0 advances it by one frame at a fixed spacing. Outputs feed the driver's trig and dacDataI_CHA..CHD inputs.

Parameters:
FRAME_GAP, 56, clk cycles between successive trig[0] pulses; must be >= 52 (driver frame is 49 clks plus margin)
INIT_FRAMES, 9, trig[0] pulses in the init pass (driver frames 1..9: CHA..CHD data, power-up, four range writes)
NUM_CH, 4, trig[0] pulses in an update pass (driver frames 1..4)

Ports:
clk  in  1  system clock, same clock as the DAC driver
reset_n  in  1  asynchronous, active-low reset
update_stb  in  1  one-cycle update request (e.g. 10 kHz tick)
in_valid  in  1  setpoint set valid
in_ready  out  1  shadow register free
in_ch_a  in  16  channel A setpoint; in_ch_b, in_ch_c, in_ch_d identical, 16 each
dac_trig  out  3  to driver trig: [0] frame advance, [1] address clear, [2] pass-active marker
dac_ch_a  out  16  held data to driver CHA; dac_ch_b, dac_ch_c, dac_ch_d identical, 16 each
busy  out  1  pass in progress
init_done  out  1  init pass completed
overrun_cnt  out  8  update_stb pulses dropped while busy or during init, saturating

Behaviour:
- Reset (async assert, sync release): state S_INIT_CLR, dac_trig=0, dac_ch_*=16'h0000, shadow=0, pending=0, in_ready=0 during reset then 1, busy=1, init_done=0, overrun_cnt=0.
- Reset asserted mid-pass aborts immediately; after release the full init pass reruns.
- Handshake: in_ready = ~pending (registered). A set is accepted when in_valid & in_ready; all four inputs go to the shadow and pending is set. in_valid while in_ready=0: the input is ignored and the producer holds it.
- FSM states: S_INIT_CLR, S_INIT_STEP, S_INIT_GAP, S_IDLE, S_CLR, S_STEP, S_GAP.
- S_INIT_CLR / S_CLR: dac_trig[1]=1 for one cycle, then go to S_INIT_STEP / S_STEP.
- S_INIT_STEP / S_STEP: dac_trig[0]=1 for one cycle. Load gap_cnt=FRAME_GAP-2 and decrement the remaining-step count. Go to the matching GAP state.
- S_*_GAP: gap_cnt counts down. At 0, go to STEP if steps remain.
  - Otherwise init pass: set init_done and go to S_IDLE.
  - Otherwise update pass: go to S_IDLE.
- Timing: trig[0] pulses are exactly FRAME_GAP cycles apart. dac_trig[2]=1 in every state except S_IDLE. busy = (state != S_IDLE).
- S_IDLE + update_stb:
  - If pending: dac_ch_* <= shadow, pending cleared.
  - Otherwise: dac_ch_* unchanged (refresh resend).
  - Go to S_CLR.
  - Latency: update_stb at edge T gives trig[1] high in cycle T+1 and the first trig[0] in T+2. The k-th trig[0] falls in T+2+k*FRAME_GAP, k=0..3. busy falls at T+2+4*FRAME_GAP.
- dac_ch_* are stable for the entire pass; they change only on the S_IDLE->S_CLR transition.
- update_stb while busy (including init) is dropped and overrun_cnt++, saturating at 8'hFF.
- Same-cycle in_valid accept and update_stb in S_IDLE:
  - Transfer uses the pre-existing shadow (old pending data, or refresh).
  - New data becomes pending for the next update.
- All outputs registered; no combinational path from inputs to outputs.

Optional Feature:
DAC_OFFSET_BINARY_EN.
- Defined: in_ch_* are two's-complement; MSB is inverted when the shadow loads (16'h8000 -> 16'h0000, 16'h0000 -> 16'h8000, 16'h7FFF -> 16'hFFFF). Reset/init hold value is 16'h8000 (mid-scale).
- Undefined: data passes straight through; reset value 16'h0000.

Decomposition:
- Package dac_seq_pkg: state enum, TRIG_ADV=0, TRIG_CLR=1, TRIG_ACT=2, default FRAME_GAP, INIT_FRAMES, NUM_CH.
- One natural sub-module, dac_seq_shadow: pending flag, in_ready, shadow registers, and the optional MSB inversion. The FSM, gap counter and overrun counter stay in the top.

Test Plan:
- Reset release, no stimulus: dac_trig[1] pulses once, then 9 trig[0] pulses 56 clks apart; init_done=1 and busy=0 after 9*56+2 clks; dac_ch_* remain 0 throughout.
- After init, load A..D=1111/2222/3333/4444 and pulse update_stb at T: trig[1] at T+1, trig[0] at T+2, T+58, T+114, T+170; dac_ch_* change at T+1 and are stable until busy falls at T+226.
- update_stb during init and again mid-pass: each is ignored and overrun_cnt steps 0->1->2; no extra trig pulses.
- Second in_valid while pending: in_ready=0 and the shadow is unchanged. Then update_stb: the first set is output, in_ready returns to 1 the next cycle, and the held second set is accepted.
- update_stb with no pending data: full pass runs with dac_ch_* unchanged.
- reset_n low mid update pass: outputs clear asynchronously, the init pass restarts, and overrun_cnt=0. With DAC_OFFSET_BINARY_EN defined, an input of 16'hFFFF outputs 16'h7FFF.
